vga_rx_monitor: RTL and testbench



---
 rtl/vga_rx_monitor_pkg.sv | 26 ++
 rtl/vga_rx_monitor_sync_edge_det.sv | 27 ++
 rtl/vga_rx_monitor.sv | 178 +++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_monitor_pkg.sv
// Shared definitions for the VGA receive monitor: default 640x480@60 timing,
// lock FSM state encoding and a saturating counter helper.
package vga_rx_monitor_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_OFFSET_DEF = 144;
    localparam int V_OFFSET_DEF = 35;

    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       ERR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_rx_monitor_sync_edge_det.sv
// Sync polarity normaliser and assert-edge detector; the edge pulse is only
// produced on pixel-strobe samples.
module sync_edge_det #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic assert_edge
);

    logic asserted;
    logic prev_q, prev_d;

    always_comb begin
        asserted    = (ACTIVE_LOW != 0) ? ~sync_in : sync_in;
        prev_d      = pix_en ? asserted : prev_q;
        assert_edge = pix_en & asserted & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: locks onto the sync stream, rebuilds active X/Y and
// reports line/frame lengths, lit-pixel count, a probed pixel and violations.
module vga_rx_monitor
    import vga_rx_monitor_pkg::*;
#(
    parameter int H_TOTAL         = H_TOTAL_DEF,
    parameter int V_TOTAL         = V_TOTAL_DEF,
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int H_OFFSET        = H_OFFSET_DEF,
    parameter int V_OFFSET        = V_OFFSET_DEF,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  pixel_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic [18:0] lit_count,
    output logic        frame_done,
    output logic [2:0]  probe_pixel,
    output logic        probe_valid,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
    localparam logic [10:0] H_OFFSET_C = 11'(H_OFFSET);
    localparam logic [10:0] V_OFFSET_C = 11'(V_OFFSET);
    localparam logic [10:0] H_END_C    = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0] V_END_C    = 11'(V_OFFSET + V_ACTIVE);

    logic h_edge, v_edge;

    sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_det (
        .clk(clk), .rst(rst), .pix_en(pix_en), .sync_in(hsync_in), .assert_edge(h_edge)
    );
    sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_det (
        .clk(clk), .rst(rst), .pix_en(pix_en), .sync_in(vsync_in), .assert_edge(v_edge)
    );

    rx_state_e   state_q, state_d;
    logic [10:0] hc_q, hc_d, vc_q, vc_d;
    logic        h_seen_q, h_seen_d, b_seen_q, b_seen_d, v_pend_q, v_pend_d;
    logic [18:0] acc_q, acc_d;
    logic        locked_q, locked_d, frame_done_q, frame_done_d;
    logic        probe_valid_q, probe_valid_d, sync_err_q, sync_err_d;
    logic [10:0] h_total_meas_q, h_total_meas_d, v_total_meas_q, v_total_meas_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [2:0]  probe_pixel_q, probe_pixel_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        boundary, check_fail, active, probe_hit, in_locked;
    logic [10:0] ax, ay;

    // hc_q/vc_q hold the previous sample's position; hc_d/vc_d are this sample's.
    always_comb begin
        boundary   = h_edge & (v_pend_q | v_edge);
        check_fail = h_edge & (((hc_q + 11'd1) != H_TOTAL_C) |
                               (boundary & ((vc_q + 11'd1) != V_TOTAL_C)));
        hc_d           = hc_q;
        vc_d           = vc_q;
        h_seen_d       = h_seen_q;
        b_seen_d       = b_seen_q;
        v_pend_d       = v_pend_q;
        h_total_meas_d = h_total_meas_q;
        v_total_meas_d = v_total_meas_q;
        if (pix_en) begin
            if (h_edge) begin
                hc_d     = 11'd0;
                h_seen_d = 1'b1;
                if (h_seen_q) h_total_meas_d = hc_q + 11'd1;
            end else begin
                hc_d = sat_inc(hc_q);
            end
            if (boundary) begin
                if (b_seen_q) v_total_meas_d = vc_q + 11'd1;
                vc_d     = 11'd0;
                v_pend_d = 1'b0;
                b_seen_d = 1'b1;
            end else begin
                if (v_edge) v_pend_d = 1'b1;
                if (h_edge) vc_d = sat_inc(vc_q);
            end
        end
        ax        = hc_d - H_OFFSET_C;
        ay        = vc_d - V_OFFSET_C;
        active    = pix_en && (hc_d >= H_OFFSET_C) && (hc_d < H_END_C) &&
                    (vc_d >= V_OFFSET_C) && (vc_d < V_END_C);
        probe_hit = active && (ax == {1'b0, probe_x}) && (ay == {1'b0, probe_y});
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH:  if (boundary) state_d = ST_MEASURE;
            ST_MEASURE: begin
                if (check_fail)    state_d = ST_SEARCH;
                else if (boundary) state_d = ST_LOCKED;
            end
            ST_LOCKED:  if (check_fail) state_d = ST_SEARCH;
            default:    state_d = ST_SEARCH;
        endcase
    end

    // The accumulator is held at zero outside LOCKED, so a count begun before
    // a lock loss can never leak into lit_count.
    always_comb begin
        in_locked     = (state_q == ST_LOCKED);
        locked_d      = (state_d == ST_LOCKED);
        frame_done_d  = in_locked & boundary & ~check_fail;
        sync_err_d    = in_locked & check_fail;
        probe_valid_d = in_locked & probe_hit;
        probe_pixel_d = probe_valid_d ? pixel_in : probe_pixel_q;
        lit_count_d   = frame_done_d ? acc_q : lit_count_q;
        err_count_d   = err_count_q;
        if (sync_err_d && (err_count_q != ERR_MAX)) err_count_d = err_count_q + 8'd1;
        if (!in_locked || boundary || check_fail) acc_d = 19'd0;
        else if (active && (pixel_in != 3'd0))    acc_d = acc_q + 19'd1;
        else                                      acc_d = acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_SEARCH;
            hc_q           <= '0;
            vc_q           <= '0;
            h_seen_q       <= 1'b0;
            b_seen_q       <= 1'b0;
            v_pend_q       <= 1'b0;
            acc_q          <= '0;
            locked_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            probe_valid_q  <= 1'b0;
            sync_err_q     <= 1'b0;
            h_total_meas_q <= '0;
            v_total_meas_q <= '0;
            lit_count_q    <= '0;
            probe_pixel_q  <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            h_seen_q       <= h_seen_d;
            b_seen_q       <= b_seen_d;
            v_pend_q       <= v_pend_d;
            acc_q          <= acc_d;
            locked_q       <= locked_d;
            frame_done_q   <= frame_done_d;
            probe_valid_q  <= probe_valid_d;
            sync_err_q     <= sync_err_d;
            h_total_meas_q <= h_total_meas_d;
            v_total_meas_q <= v_total_meas_d;
            lit_count_q    <= lit_count_d;
            probe_pixel_q  <= probe_pixel_d;
            err_count_q    <= err_count_d;
        end
    end

    assign locked       = locked_q;
    assign h_total_meas = h_total_meas_q;
    assign v_total_meas = v_total_meas_q;
    assign lit_count    = lit_count_q;
    assign frame_done   = frame_done_q;
    assign probe_pixel  = probe_pixel_q;
    assign probe_valid  = probe_valid_q;
    assign sync_err     = sync_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using scaled-down timing (40x26 main,
// 6x4 for the error-saturation run) so the whole run stays short.
module tb_vga_rx_monitor;

    localparam int HT = 40, VT = 26, HA = 28, VA = 18, HO = 8, VO = 6;
    localparam int T_HT = 6, T_VT = 4;

    logic        clk = 1'b0;
    logic        rst, pix_en, hsync_in, vsync_in;
    logic [2:0]  pixel_in;
    logic [9:0]  probe_x, probe_y;

    logic        locked, frame_done, probe_valid, sync_err;
    logic [10:0] h_total_meas, v_total_meas;
    logic [18:0] lit_count;
    logic [2:0]  probe_pixel;
    logic [7:0]  err_count;

    logic        s_locked, s_frame_done, s_probe_valid, s_sync_err;
    logic [10:0] s_h_total_meas, s_v_total_meas;
    logic [18:0] s_lit_count;
    logic [2:0]  s_probe_pixel;
    logic [7:0]  s_err_count;

    always #5 clk = ~clk;

    vga_rx_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                     .H_OFFSET(HO), .V_OFFSET(VO), .SYNC_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_in(pixel_in), .probe_x(probe_x), .probe_y(probe_y), .locked(locked),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .lit_count(lit_count),
        .frame_done(frame_done), .probe_pixel(probe_pixel), .probe_valid(probe_valid),
        .sync_err(sync_err), .err_count(err_count)
    );

    vga_rx_monitor #(.H_TOTAL(T_HT), .V_TOTAL(T_VT), .H_ACTIVE(2), .V_ACTIVE(2),
                     .H_OFFSET(2), .V_OFFSET(1), .SYNC_ACTIVE_LOW(1)) dut_sat (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_in(pixel_in), .probe_x(probe_x), .probe_y(probe_y), .locked(s_locked),
        .h_total_meas(s_h_total_meas), .v_total_meas(s_v_total_meas), .lit_count(s_lit_count),
        .frame_done(s_frame_done), .probe_pixel(s_probe_pixel), .probe_valid(s_probe_valid),
        .sync_err(s_sync_err), .err_count(s_err_count)
    );

    // Pulse counters; any spurious or stretched pulse shows up as an extra count.
    int fd_cnt = 0, pv_cnt = 0, se_cnt = 0, se2_cnt = 0;
    always @(negedge clk) begin
        if (frame_done  === 1'b1) fd_cnt  = fd_cnt + 1;
        if (probe_valid === 1'b1) pv_cnt  = pv_cnt + 1;
        if (sync_err    === 1'b1) se_cnt  = se_cnt + 1;
        if (s_sync_err  === 1'b1) se2_cnt = se2_cnt + 1;
    end

    int n_cmp = 0, n_bad = 0;
    int cur_ht = HT, cur_vt = VT, frame_no = 0;
    int stretch_y = -1, stretch_x = -1;
    bit fast_mode = 1'b0, rand_gaps = 1'b0, vs_mid = 1'b0, pattern_on = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // 8x8 block of 111 at active (10..17,10..17) with 101 at (13,10), 001 at the two
    // active corners, nonzero pixels on the columns/rows just outside the active area.
    function automatic logic [2:0] pix_at(input int x, input int y);
        int ax, ay;
        ax = x - HO;
        ay = y - VO;
        if (y == VO - 1 || y == VO + VA) return 3'b010;
        if (x == HO - 1 || x == HO + HA) return 3'b100;
        if (ax == 13 && ay == 10) return 3'b101;
        if (ax >= 10 && ax <= 17 && ay >= 10 && ay <= 17) return 3'b111;
        if ((ax == 0 && ay == 0) || (ax == HA - 1 && ay == VA - 1)) return 3'b001;
        return 3'b000;
    endfunction

    task automatic put_sample(input logic h, input logic v, input logic [2:0] p);
        @(negedge clk);
        hsync_in = ~h;
        vsync_in = ~v;
        pixel_in = p;
        pix_en   = 1'b1;
        if (!fast_mode) begin
            @(negedge clk);
            pix_en = 1'b0;
            if (rand_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic put_lines(input int y0, input int y1, input int short_y);
        int len;
        logic h, v;
        for (int y = y0; y <= y1; y++) begin
            len = (y == short_y) ? cur_ht - 1 : cur_ht;
            for (int x = 0; x < len; x++) begin
                h = (x < 4);
                v = (y < 2) || (vs_mid && y == cur_vt - 1 && x >= 7);
                if (y == stretch_y && x == stretch_x) repeat (100) @(negedge clk);
                put_sample(h, v, pattern_on ? pix_at(x, y) : 3'b000);
            end
        end
    endtask

    task automatic put_frame(input int short_y);
        put_lines(0, cur_vt - 1, short_y);
        frame_no++;
        if (!fast_mode)
            $display("frame %0d: locked=%0b h=%0d v=%0d lit=%0d err=%0d fd=%0d pv=%0d",
                     frame_no, locked, h_total_meas, v_total_meas, lit_count, err_count,
                     fd_cnt, pv_cnt);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; pixel_in = 3'd0;
        probe_x = 10'd13; probe_y = 10'd10;
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_htot", h_total_meas, 0);
        check("rst_vtot", v_total_meas, 0);
        check("rst_lit", lit_count, 0);
        check("rst_err", err_count, 0);
        check("rst_ppix", probe_pixel, 0);
        check("rst_pulses", {frame_done, probe_valid, sync_err}, 0);
        rst = 1'b0;

        put_frame(-1);
        put_frame(-1);
        check("lock_after_2", locked, 1);
        check("htot_clean", h_total_meas, 40);
        check("vtot_clean", v_total_meas, 26);
        check("err_clean", err_count, 0);
        check("fd_none_yet", fd_cnt, 0);
        check("lit_none_yet", lit_count, 0);
        check("pv_f2", pv_cnt, 1);
        check("ppix_f2", probe_pixel, 3'b101);

        put_frame(-1);
        check("fd_f3", fd_cnt, 1);
        check("lit_f3", lit_count, 66);
        check("pv_f3", pv_cnt, 2);

        probe_x = 10'd28;
        put_frame(-1);
        check("pv_out_of_range", pv_cnt, 2);
        check("fd_f4", fd_cnt, 2);
        check("lit_f4", lit_count, 66);

        probe_x = 10'd27; probe_y = 10'd17;
        put_frame(-1);
        check("pv_corner", pv_cnt, 3);
        check("ppix_corner", probe_pixel, 3'b001);

        put_frame(10);
        check("se_short", se_cnt, 1);
        check("err_short", err_count, 1);
        check("unlock_short", locked, 0);
        check("fd_f6", fd_cnt, 4);
        put_frame(-1);
        check("relock_wait", locked, 0);
        check("fd_f7", fd_cnt, 4);
        put_frame(-1);
        check("relock", locked, 1);
        check("fd_f8", fd_cnt, 4);
        check("pv_f8", pv_cnt, 4);
        put_frame(-1);
        check("fd_f9", fd_cnt, 5);
        check("lit_f9", lit_count, 66);

        rand_gaps = 1'b1; vs_mid = 1'b1; stretch_y = 5; stretch_x = 20;
        put_frame(-1);
        stretch_y = -1;
        put_frame(-1);
        check("htot_gaps", h_total_meas, 40);
        check("vtot_gaps", v_total_meas, 26);
        check("locked_gaps", locked, 1);
        check("se_gaps", se_cnt, 1);
        check("fd_gaps", fd_cnt, 7);
        check("pv_gaps", pv_cnt, 7);
        check("lit_gaps", lit_count, 66);

        rand_gaps = 1'b0; vs_mid = 1'b0;
        put_lines(0, 11, -1);
        #2 rst = 1'b1;
        #1;
        check("arst_locked", locked, 0);
        check("arst_htot", h_total_meas, 0);
        check("arst_vtot", v_total_meas, 0);
        check("arst_lit", lit_count, 0);
        check("arst_err", err_count, 0);
        check("arst_ppix", probe_pixel, 0);
        @(negedge clk);
        rst = 1'b0;
        put_lines(12, VT - 1, -1);
        put_frame(-1);
        check("post_rst_unlocked", locked, 0);
        check("post_rst_vtot", v_total_meas, 0);
        put_frame(-1);
        check("post_rst_locked", locked, 1);
        check("post_rst_htot", h_total_meas, 40);
        check("post_rst_vtot2", v_total_meas, 26);
        check("post_rst_fd", fd_cnt, 8);
        check("post_rst_pv", pv_cnt, 8);

        fast_mode = 1'b1; pattern_on = 1'b0; cur_ht = T_HT; cur_vt = T_VT;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            put_frame(-1);
            put_frame(-1);
            if (i == 1) begin
                check("sat_locked", s_locked, 1);
                check("sat_htot", s_h_total_meas, 6);
                check("sat_vtot", s_v_total_meas, 4);
            end
            put_frame(1);
            if (i == 1) begin
                check("sat_err1", s_err_count, 1);
                check("sat_unlock", s_locked, 0);
            end
            if (i == 255) check("sat_err255", s_err_count, 255);
        end
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        check("sat_err_hold", s_err_count, 255);
        check("sat_pulses", se2_cnt, 260);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
